// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter and sequencer for an 8:1 datapath mux shared by eight
// requesters. Grants one lane at a time, drives the registered mux select,
// registers the selected lane's data and caps how long one lane may hold the
// grant so that no requester can starve the others.
module mux8_rr_arbiter #(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          i_req,
  input  logic [8*DATA_W-1:0] i_dataIn,
  output logic [7:0]          o_gnt,
  output logic [2:0]          o_sel,
  output logic                o_busy,
  output logic                o_outValid,
  output logic [DATA_W-1:0]   o_outData
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } stateT;

  // Last legal value of the hold counter before the grant is forcibly released.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  // Returns {found, lane}: the first requesting lane when searching upward
  // from 'start' and wrapping modulo 8.
  function automatic logic [3:0] pickLane(input logic [7:0] reqs,
                                          input logic [2:0] start);
    logic [2:0] idx;
    logic [3:0] result;
    result = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      idx = start + i[2:0];
      if (!result[3] && reqs[idx]) begin
        result = {1'b1, idx};
      end
    end
    return result;
  endfunction

  logic [1:0]        r_rstSync;
  logic              w_rstN;

  stateT             r_state;
  stateT             w_stateNext;
  logic [7:0]        r_gnt;
  logic [7:0]        w_gntNext;
  logic [2:0]        r_sel;
  logic [2:0]        w_selNext;
  logic [2:0]        r_ptr;
  logic [2:0]        w_ptrNext;
  logic [7:0]        r_hcnt;
  logic [7:0]        w_hcntNext;
  logic              r_outValid;
  logic [DATA_W-1:0] r_outData;

  logic [3:0]        w_idlePick;
  logic [2:0]        w_releasePtr;
  logic [3:0]        w_releasePick;
  logic              w_holdContinue;
  logic [DATA_W-1:0] w_laneData;

  // Reset enters asynchronously but leaves on a clock edge, so the state
  // flops never see a deassertion racing the clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstSync <= 2'b00;
    end else begin
      r_rstSync <= {r_rstSync[0], 1'b1};
    end
  end

  assign w_rstN = r_rstSync[1];

  // Two arbitration results are needed: one from the stored pointer (idle
  // start-up) and one from the pointer that a release would install (g+1),
  // so a release can hand over to the next lane without an idle bubble.
  assign w_idlePick    = pickLane(i_req, r_ptr);
  assign w_releasePtr  = r_sel + 3'd1;
  assign w_releasePick = pickLane(i_req, w_releasePtr);

  // The current owner keeps the mux while it still requests and has not
  // used up its hold budget.
  assign w_holdContinue = i_req[r_sel] && (r_hcnt < HOLD_LAST);

  assign w_laneData = i_dataIn[r_sel*DATA_W +: DATA_W];

  // Next-state and next-grant decision for the IDLE/GRANT sequencer.
  always_comb begin
    w_stateNext = r_state;
    w_gntNext   = r_gnt;
    w_selNext   = r_sel;
    w_ptrNext   = r_ptr;
    w_hcntNext  = r_hcnt;

    case (r_state)
      IDLE: begin
        w_gntNext = 8'h00;
        if (w_idlePick[3]) begin
          w_stateNext = GRANT;
          w_selNext   = w_idlePick[2:0];
          w_gntNext   = 8'h01 << w_idlePick[2:0];
          w_hcntNext  = 8'h00;
        end
      end

      GRANT: begin
        if (w_holdContinue) begin
          w_hcntNext = r_hcnt + 8'h01;
        end else begin
          // Releasing lane g moves priority to g+1; when g is the only
          // requester the wrapped search reaches it last and re-grants it.
          w_ptrNext = w_releasePtr;
          if (w_releasePick[3]) begin
            w_stateNext = GRANT;
            w_selNext   = w_releasePick[2:0];
            w_gntNext   = 8'h01 << w_releasePick[2:0];
            w_hcntNext  = 8'h00;
          end else begin
            w_stateNext = IDLE;
            w_gntNext   = 8'h00;
            w_hcntNext  = 8'h00;
          end
        end
      end

      default: begin
        w_stateNext = IDLE;
        w_gntNext   = 8'h00;
      end
    endcase
  end

  // Sequencer state register: grant, select, priority pointer and hold count.
  always_ff @(posedge clk or negedge w_rstN) begin
    if (!w_rstN) begin
      r_state <= IDLE;
      r_gnt   <= 8'h00;
      r_sel   <= 3'd0;
      r_ptr   <= 3'd0;
      r_hcnt  <= 8'h00;
    end else begin
      r_state <= w_stateNext;
      r_gnt   <= w_gntNext;
      r_sel   <= w_selNext;
      r_ptr   <= w_ptrNext;
      r_hcnt  <= w_hcntNext;
    end
  end

  // Output register of the shared mux: follows the granted lane one cycle
  // behind the grant and freezes its last word while nothing is granted.
  always_ff @(posedge clk or negedge w_rstN) begin
    if (!w_rstN) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
    end else begin
      r_outValid <= (r_state == GRANT);
      if (r_state == GRANT) begin
        r_outData <= w_laneData;
      end
    end
  end

  assign o_gnt      = r_gnt;
  assign o_sel      = r_sel;
  assign o_busy     = (r_state == GRANT);
  assign o_outValid = r_outValid;
  assign o_outData  = r_outData;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed testbench for mux8_rr_arbiter. Two instances share all inputs:
// dutA uses a short hold limit (4) and dutB the default (16).
module tb_mux8_rr_arbiter;

  localparam int DATA_W = 8;

  logic                clk;
  logic                rst_n;
  logic [7:0]          req;
  logic [8*DATA_W-1:0] dataIn;

  logic [7:0]          gntA;
  logic [2:0]          selA;
  logic                busyA;
  logic                validA;
  logic [DATA_W-1:0]   dataA;

  logic [7:0]          gntB;
  logic [2:0]          selB;
  logic                busyB;
  logic                validB;
  logic [DATA_W-1:0]   dataB;

  int checks;
  int errors;

  typedef struct {
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       valid;
    logic [7:0] data;
  } vecT;

  vecT vecs[15];

  mux8_rr_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(4)) dutA (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (req),
    .i_dataIn  (dataIn),
    .o_gnt     (gntA),
    .o_sel     (selA),
    .o_busy    (busyA),
    .o_outValid(validA),
    .o_outData (dataA)
  );

  mux8_rr_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(16)) dutB (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (req),
    .i_dataIn  (dataIn),
    .o_gnt     (gntB),
    .o_sel     (selB),
    .o_busy    (busyB),
    .o_outValid(validB),
    .o_outData (dataB)
  );

  // 10-unit clock period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Drive a request pattern, then sample 1 unit after the next rising edge.
  task automatic applyStimulus(input logic [7:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  // Internal reset leaves two edges after rst_n rises; end on a falling edge
  // so the next edge seen by applyStimulus is the first functional one.
  task automatic doReset();
    req   = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    req    = 8'h00;
    rst_n  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dataIn[i*DATA_W +: DATA_W] = 8'hA0 + 8'(i);
    end

    // Single requester on lane 2, then lane data swept one-hot 0..7.
    vecs[0]  = '{8'h04, 8'h04, 3'd2, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{8'h04, 8'h04, 3'd2, 1'b1, 1'b1, 8'hA2};
    vecs[2]  = '{8'h04, 8'h04, 3'd2, 1'b1, 1'b1, 8'hA2};
    vecs[3]  = '{8'h00, 8'h00, 3'd2, 1'b0, 1'b1, 8'hA2};
    vecs[4]  = '{8'h00, 8'h00, 3'd2, 1'b0, 1'b0, 8'hA2};
    vecs[5]  = '{8'h01, 8'h01, 3'd0, 1'b1, 1'b0, 8'hA2};
    vecs[6]  = '{8'h02, 8'h02, 3'd1, 1'b1, 1'b1, 8'hA0};
    vecs[7]  = '{8'h04, 8'h04, 3'd2, 1'b1, 1'b1, 8'hA1};
    vecs[8]  = '{8'h08, 8'h08, 3'd3, 1'b1, 1'b1, 8'hA2};
    vecs[9]  = '{8'h10, 8'h10, 3'd4, 1'b1, 1'b1, 8'hA3};
    vecs[10] = '{8'h20, 8'h20, 3'd5, 1'b1, 1'b1, 8'hA4};
    vecs[11] = '{8'h40, 8'h40, 3'd6, 1'b1, 1'b1, 8'hA5};
    vecs[12] = '{8'h80, 8'h80, 3'd7, 1'b1, 1'b1, 8'hA6};
    vecs[13] = '{8'h00, 8'h00, 3'd7, 1'b0, 1'b1, 8'hA7};
    vecs[14] = '{8'h00, 8'h00, 3'd7, 1'b0, 1'b0, 8'hA7};

    // Reset state.
    doReset();
    checkOutput("reset gnt",   32'(gntA),   32'h00);
    checkOutput("reset sel",   32'(selA),   32'h0);
    checkOutput("reset busy",  32'(busyA),  32'h0);
    checkOutput("reset valid", 32'(validA), 32'h0);
    checkOutput("reset data",  32'(dataA),  32'h00);
    checkOutput("reset gntB",  32'(gntB),   32'h00);

    // Table-driven vectors on the short-hold instance.
    for (int v = 0; v < 15; v++) begin
      applyStimulus(vecs[v].req);
      checkOutput($sformatf("vec%0d gnt", v),   32'(gntA),   32'(vecs[v].gnt));
      checkOutput($sformatf("vec%0d sel", v),   32'(selA),   32'(vecs[v].sel));
      checkOutput($sformatf("vec%0d busy", v),  32'(busyA),  32'(vecs[v].busy));
      checkOutput($sformatf("vec%0d valid", v), 32'(validA), 32'(vecs[v].valid));
      checkOutput($sformatf("vec%0d data", v),  32'(dataA),  32'(vecs[v].data));
    end

    // All lanes requesting, hold limit 4: lanes rotate 0..7,0 every 4 cycles
    // with no empty cycle between owners.
    doReset();
    for (int t = 0; t < 33; t++) begin
      applyStimulus(8'hFF);
      checkOutput($sformatf("rotate t%0d gnt", t), 32'(gntA), 32'(8'h01 << ((t / 4) % 8)));
    end

    // Mid-grant requests from other lanes are ignored; on release the
    // pointer moves past lane 5, so lane 6 wins before lane 3.
    doReset();
    applyStimulus(8'h20);
    checkOutput("hold5 gnt", 32'(gntB), 32'h20);
    applyStimulus(8'h68);
    checkOutput("ignore gnt", 32'(gntB), 32'h20);
    applyStimulus(8'h48);
    checkOutput("next6 gnt", 32'(gntB), 32'h40);
    checkOutput("next6 sel", 32'(selB), 32'd6);
    checkOutput("next6 busy", 32'(busyB), 32'h1);
    applyStimulus(8'h08);
    checkOutput("next3 gnt", 32'(gntB), 32'h08);
    checkOutput("next3 sel", 32'(selB), 32'd3);

    // Lone lane 7 with hold limit 16: re-granted on every timeout without a
    // gap; timeouts fall on cycles 16, 32, 48. Lane 0 joining at cycle 40 is
    // ignored until the timeout at 48, which leaves the pointer at 0.
    doReset();
    for (int t = 0; t < 40; t++) begin
      applyStimulus(8'h80);
      checkOutput($sformatf("lone7 t%0d gnt", t), 32'(gntB), 32'h80);
    end
    for (int t = 40; t < 49; t++) begin
      applyStimulus(8'h81);
      checkOutput($sformatf("lone7 t%0d gnt", t), 32'(gntB),
                  (t < 48) ? 32'h80 : 32'h01);
    end

    // Asynchronous reset while lane 1 owns the mux.
    doReset();
    applyStimulus(8'h02);
    applyStimulus(8'h02);
    checkOutput("pre-reset data", 32'(dataA), 32'hA1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async gnt",   32'(gntA),   32'h00);
    checkOutput("async sel",   32'(selA),   32'h0);
    checkOutput("async busy",  32'(busyA),  32'h0);
    checkOutput("async valid", 32'(validA), 32'h0);
    checkOutput("async data",  32'(dataA),  32'h00);
    req = 8'h03;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("post-reset gnt", 32'(gntA), 32'h01);
    checkOutput("post-reset sel", 32'(selA), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for an 8:1 datapath mux shared by eight requesters.
- Grants one lane at a time, drives the 3-bit mux select, registers the selected lane's data, and enforces a maximum hold time so no lane can starve the others.
- Sits in front of the shared 8:1 mux / output register.

Parameters:
- DATA_W, 8, width of each lane's data word.
- MAX_HOLD, 16, maximum consecutive cycles one lane may hold the grant (legal range 2..255).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  per-lane request; bit i set means lane i wants the mux.
- data_in  input  8*DATA_W  lane data, concatenated; lane i occupies bits [i*DATA_W +: DATA_W].
- gnt  output  8  one-hot grant, registered.
- sel  output  3  binary index of the granted lane, registered; drives the mux select.
- busy  output  1  high while in state GRANT.
- out_valid  output  1  registered; high when out_data holds granted-lane data.
- out_data  output  DATA_W  registered mux output.

Behaviour:
- Reset (async assert, sync deassert inside the block):
  - state=IDLE, gnt=0, sel=0, busy=0, out_valid=0, out_data=0.
  - Priority pointer ptr=0, hold counter hcnt=0.
- Arbitration function:
  - Search starts at lane ptr and proceeds ptr, ptr+1, ..., wrapping modulo 8.
  - First lane with req set wins.
- State IDLE:
  - If any req bit is set at edge N: gnt/sel = winner, state=GRANT, hcnt=0, all visible after edge N.
  - Else stay in IDLE with gnt=0.
  - Request-to-grant latency is 1 cycle.
- State GRANT, lane g = sel:
  - Continue: req[g]=1 and hcnt<MAX_HOLD-1. Keep gnt, hcnt++.
  - Release: req[g]=0, or hcnt==MAX_HOLD-1 (timeout).
    - Set ptr=g+1 mod 8, then arbitrate in the same cycle using the new pointer.
    - Winner found: gnt/sel switch directly to it with no idle bubble; hcnt=0; stay in GRANT.
    - No winner: state=IDLE, gnt=0, sel holds its last value.
  - Timeout with only lane g requesting: lane g is re-granted (wrap search reaches g last); hcnt restarts at 0. gnt stays high continuously.
- Datapath:
  - Every cycle: out_data <= data_in lane sel (current registered sel).
  - out_valid <= busy.
  - out_data/out_valid therefore lag gnt by exactly 1 cycle.
  - In IDLE: out_valid=0 and out_data holds its last value.
- gnt is always one-hot or zero; never more than one bit set.
- Requests for lanes other than g are ignored mid-grant and cause no change until release.
- Reset asserted mid-grant: all outputs return to reset values immediately (asynchronously); ptr returns to 0.
- Width: hcnt is 8 bits; ptr is 3 bits with natural wrap (7+1=0).

Test Plan:
- Reset, then req=8'b0000_0100 held for 3 cycles: gnt=8'h04 and sel=2 one cycle after req; out_valid rises one cycle later with out_data = lane-2 data. Drop req: gnt=0 next cycle, out_valid=0 one cycle after that.
- req=8'hFF held constant, MAX_HOLD=4: grant order 0,1,2,...,7,0. Each lane holds exactly 4 cycles; gnt never 0 between lanes.
- Lane 5 holds the grant; lane 3 and lane 6 raise req; lane 5 drops req: next grant is lane 6 (ptr=6), then lane 3 after lane 6 releases.
- Only lane 7 requests, held 40 cycles, MAX_HOLD=16: gnt=8'h80 stays high continuously; hcnt wraps at 15 with no gap; ptr becomes 0.
- Lane 1 granted; assert rst_n=0 mid-cycle: gnt, sel, busy, out_valid and out_data go to 0 without waiting for clk. After release with req=8'h03, lane 0 is granted first (ptr=0).
- Lane-data check: DATA_W=8, lane i data = 8'hA0+i, req cycled one-hot 0..7: out_data equals 8'hA0+sel one cycle after each grant.
